// File: rtl/config_stream_loader.sv
// Configuration stream front-end: takes a header word plus (address, data) pairs
// and broadcasts each data word on a shared bus with a one-hot per-tile strobe.
module config_stream_loader #(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_data_i,
    output logic [31:0]          config_data_o,
    output logic [NUM_TILES-1:0] config_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    // state  | meaning
    // IDLE   | waiting for a header word
    // ADDR   | waiting for the address word of a pair
    // DATA   | waiting for the data word of a pair
    // COMMIT | strobe cycle for the pair just received, input stalled
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [31:0] NUM_TILES_U = NUM_TILES;

    state_e                 state_q;
    logic                   in_ready_q;
    logic [31:0]            config_data_q;
    logic [NUM_TILES-1:0]   config_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [15:0]            remaining_q;
    logic [ADDR_W-1:0]      addr_q;

    logic                   accept;
    logic                   addr_ok;
    logic [NUM_TILES-1:0]   en_dec;

    assign accept  = in_valid_i && in_ready_q;
    assign addr_ok = (32'(addr_q) < NUM_TILES_U);

    always_comb begin
        en_dec = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (32'(addr_q) == i[31:0]) begin
                en_dec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            config_data_q <= '0;
            config_en_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            remaining_q   <= '0;
            addr_q        <= '0;
        end else begin
            done_q      <= 1'b0;
            config_en_q <= '0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        remaining_q <= in_data_i[15:0];
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        // An empty frame completes in place, busy covers the done cycle
                        if (in_data_i[15:0] == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ADDR;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_q  <= in_data_i[ADDR_W-1:0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        config_data_q <= in_data_i;
                        if (addr_ok) begin
                            config_en_q <= en_dec;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (remaining_q == 16'd1) begin
                            done_q <= 1'b1;
                        end
                        remaining_q <= remaining_q - 16'd1;
                        in_ready_q  <= 1'b0;
                        state_q     <= COMMIT;
                    end
                end
                COMMIT: begin
                    in_ready_q <= 1'b1;
                    if (remaining_q == 16'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign config_data_o = config_data_q;
    assign config_en_o   = config_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: frames driven word by word, outputs
// checked on the falling clock edge against hand-computed values.
module tb_config_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] config_data;
    logic [15:0] config_en;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pulse = 0;

    config_stream_loader #(.NUM_TILES(16), .ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .config_data_o(config_data),
        .config_en_o  (config_en),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a word at a falling edge and return at the falling edge after it is taken.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int k, input string tag);
        in_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk({tag, "_en"}, {16'd0, config_en}, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        // 1. reset release
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        chk("rst_en", {16'd0, config_en}, 32'd0);
        chk("rst_data", config_data, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);
        chk("rel_en", {16'd0, config_en}, 32'd0);

        // 2. single pair
        send(32'h0000_0001);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        send(32'h0000_0003);
        send(32'hDEAD_BEEF);
        in_valid = 1'b0;
        chk("t2_en", {16'd0, config_en}, 32'h0008);
        chk("t2_data", config_data, 32'hDEAD_BEEF);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("t2_en_off", {16'd0, config_en}, 32'd0);
        chk("t2_busy_off", {31'd0, busy}, 32'd0);
        chk("t2_done_off", {31'd0, done}, 32'd0);
        chk("t2_hold", config_data, 32'hDEAD_BEEF);

        // 3. three back-to-back pairs; upper header and address bits ignored
        send(32'hABCD_0003);
        send(32'h0000_0000);
        send(32'h0000_0011);
        chk("t3_en0", {16'd0, config_en}, 32'h0001);
        chk("t3_d0", config_data, 32'h11);
        chk("t3_done0", {31'd0, done}, 32'd0);
        chk("t3_rdy0", {31'd0, in_ready}, 32'd0);
        last_pulse = cyc;
        send(32'h0000_000F);
        chk("t3_rdy_addr", {31'd0, in_ready}, 32'd1);
        send(32'h0000_0022);
        chk("t3_en1", {16'd0, config_en}, 32'h8000);
        chk("t3_d1", config_data, 32'h22);
        chk("t3_gap1", cyc - last_pulse, 32'd3);
        last_pulse = cyc;
        send(32'h1234_5607);
        send(32'h0000_0033);
        in_valid = 1'b0;
        chk("t3_en2", {16'd0, config_en}, 32'h0080);
        chk("t3_d2", config_data, 32'h33);
        chk("t3_done2", {31'd0, done}, 32'd1);
        chk("t3_gap2", cyc - last_pulse, 32'd3);
        @(negedge clk);
        chk("t3_busy_off", {31'd0, busy}, 32'd0);

        // 4. out-of-range address
        send(32'h0000_0002);
        send(32'h0000_0014);
        send(32'h0000_00AA);
        chk("t4_en_bad", {16'd0, config_en}, 32'd0);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_done_bad", {31'd0, done}, 32'd0);
        send(32'h0000_0002);
        send(32'h0000_00BB);
        in_valid = 1'b0;
        chk("t4_en", {16'd0, config_en}, 32'h0004);
        chk("t4_data", config_data, 32'hBB);
        chk("t4_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t4_err_sticky", {31'd0, err}, 32'd1);
        chk("t4_busy_off", {31'd0, busy}, 32'd0);

        // 5. stalled frame with 5-cycle gaps
        send(32'h0000_0002);
        chk("t5_err_clr", {31'd0, err}, 32'd0);
        idle_cycles(5, "t5_g0");
        send(32'h0000_0001);
        idle_cycles(5, "t5_g1");
        chk("t5_hold", config_data, 32'hBB);
        send(32'h0000_0055);
        in_valid = 1'b0;
        chk("t5_en0", {16'd0, config_en}, 32'h0002);
        chk("t5_d0", config_data, 32'h55);
        @(negedge clk);
        idle_cycles(5, "t5_g2");
        send(32'h0000_0009);
        idle_cycles(5, "t5_g3");
        send(32'h0000_0066);
        in_valid = 1'b0;
        chk("t5_en1", {16'd0, config_en}, 32'h0200);
        chk("t5_d1", config_data, 32'h66);
        chk("t5_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t5_busy_off", {31'd0, busy}, 32'd0);

        // 6. empty frame, then reset mid-frame, then a fresh frame
        send(32'h0000_0000);
        in_valid = 1'b0;
        chk("t6_done0", {31'd0, done}, 32'd1);
        chk("t6_en0", {16'd0, config_en}, 32'd0);
        @(negedge clk);
        chk("t6_done_off", {31'd0, done}, 32'd0);
        chk("t6_busy_off", {31'd0, busy}, 32'd0);
        send(32'h0000_0001);
        send(32'h0000_0005);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_en", {16'd0, config_en}, 32'd0);
        chk("t6_rst_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_strobe", {16'd0, config_en}, 32'd0);
        end
        send(32'h0000_0001);
        send(32'h0000_0004);
        send(32'h0000_0077);
        in_valid = 1'b0;
        chk("t6_en", {16'd0, config_en}, 32'h0010);
        chk("t6_data", config_data, 32'h77);
        chk("t6_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t6_end_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog timeout");
    end

endmodule
